// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    // Byte address bit where the word index starts.
    localparam int DMEM_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH_WORDS x 32 storage, synchronous write, asynchronous read
//
// Ports:
//   clk_i    - clock, write on rising edge
//   we_i     - write enable
//   waddr_i  - write word index
//   wdata_i  - write data
//   raddr_i  - read word index
//   rdata_o  - combinational read data
// Contents are intentionally not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with programmable wait states
//
// Ports:
//   clk_i        - clock
//   rst_i        - asynchronous active-low reset
//   MemRead_i    - read request (level-held while stalled)
//   MemWrite_i   - write request (level-held); wins over MemRead_i
//   Addr_i       - byte address; word index taken from bit 2 upward, wraps modulo depth
//   WriteData_i  - store data
//   ReadData_o   - registered load data, changes only when a read completes
//   Stall_o      - freeze the front of the pipeline this cycle
//   Done_o       - one-cycle pulse in the response cycle
//   Misalign_o   - misaligned-access pulse (optional feature, else tied 0)
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] ReadData_o,
    output logic        Stall_o,
    output logic        Done_o,
    output logic        Misalign_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    op_e              op_q,    op_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic             mis_q,   mis_d;
`endif

    logic        req;
    logic        stall_c;
    logic        arr_we;
    logic [31:0] arr_rdata;

    // Upper address bits wrap; low bits only matter with the trap enabled.
    logic unused_addr;
    assign unused_addr = ^{Addr_i[31:DMEM_ADDR_LSB+IDX_W], Addr_i[DMEM_ADDR_LSB-1:0]};

    assign req = MemRead_i | MemWrite_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        stall_c = 1'b0;
        arr_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall_c = req;
                if (req) begin
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (Addr_i[DMEM_ADDR_LSB-1:0] != '0) begin
                        // Trap: skip the array entirely and respond next cycle.
                        mis_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        mis_d   = 1'b0;
                        op_d    = MemWrite_i ? OP_WR : OP_RD;
                        idx_d   = Addr_i[DMEM_ADDR_LSB +: IDX_W];
                        wdata_d = WriteData_i;
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
`else
                    op_d    = MemWrite_i ? OP_WR : OP_RD;
                    idx_d   = Addr_i[DMEM_ADDR_LSB +: IDX_W];
                    wdata_d = WriteData_i;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    // Array access happens only on the final BUSY edge, so a
                    // reset earlier in BUSY never touches the array.
                    state_d = RESP;
                    if (op_q == OP_WR) begin
                        arr_we = 1'b1;
                    end else begin
                        rdata_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (idx_q),
        .rdata_o (arr_rdata)
    );

    // Stall is combinational on req in IDLE; mask it while reset is held.
    assign Stall_o    = stall_c & rst_i;
    assign Done_o     = (state_q == RESP);
    assign ReadData_o = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign Misalign_o = (state_q == RESP) & mis_q;
`else
    assign Misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic [31:0] ReadData_o;
    logic        Stall_o;
    logic        Done_o;
    logic        Misalign_o;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Addr_i      (Addr_i),
        .WriteData_i (WriteData_i),
        .ReadData_o  (ReadData_o),
        .Stall_o     (Stall_o),
        .Done_o      (Done_o),
        .Misalign_o  (Misalign_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_done_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model: word memory, known-valid flags, expected load register.
    logic [31:0] mem_m [DEPTH];
    bit          val_m [DEPTH];
    logic [31:0] rd_m;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // Update the model for one request; returns expected ReadData_o after it.
    task automatic model_apply(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int i;
        i = widx(addr);
        if (wr) begin
            mem_m[i] = wdata;
            val_m[i] = 1'b1;
        end else if (rd) begin
            rd_m = mem_m[i];
        end
    endtask

    // Called at a negedge; request is seen in IDLE this cycle. Returns at the
    // negedge of the following IDLE cycle so accesses can run back to back.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit scramble,
                          input logic [31:0] exp_rd);
        MemRead_i   = rd;
        MemWrite_i  = wr;
        Addr_i      = addr;
        WriteData_i = wdata;
        for (int c = 0; c <= W + 1; c++) begin
            #1;
            chk("stall", {31'b0, Stall_o}, {31'b0, c <= W});
            chk("done", {31'b0, Done_o}, {31'b0, c == W + 1});
            chk("misalign", {31'b0, Misalign_o}, 32'd0);
            if (c == W + 1) begin
                chk("rdata", ReadData_o, exp_rd);
                last_done_cyc = cyc;
            end
            @(negedge clk_i);
            if (scramble && c <= W) begin
                // Keep req high but change everything else; must be ignored.
                MemRead_i   = 1'($urandom);
                MemWrite_i  = ~MemRead_i | 1'($urandom);
                Addr_i      = $urandom;
                WriteData_i = $urandom;
            end
        end
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    task automatic idle(input int n);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            #1;
            chk("idle_stall", {31'b0, Stall_o}, 32'd0);
            chk("idle_done", {31'b0, Done_o}, 32'd0);
            chk("idle_rdata", ReadData_o, rd_m);
            @(negedge clk_i);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        logic [31:0] a;
        logic        r;
        logic        w;
        int          ix;

        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_1234, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_1234};
        tbl[4]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0055, 32'h0000_1234};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0055};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h0000_0055};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0000_0055};
        tbl[8]  = '{1'b1, 1'b0, 32'hFFFF_F004, 32'h0,         32'hCAFE_F00D};
        tbl[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'hCAFE_F00D};
        tbl[10] = '{1'b1, 1'b0, 32'h1234_5FFC, 32'h0,         32'hA5A5_A5A5};

        for (int i = 0; i < DEPTH; i++) val_m[i] = 1'b0;
        rd_m = 32'h0;

        // Reset state, including Stall_o masked while reset is held.
        rst_i       = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        Addr_i      = 32'h0;
        WriteData_i = 32'h0;
        repeat (2) @(negedge clk_i);
        MemRead_i = 1'b1;
        #1;
        chk("rst_stall", {31'b0, Stall_o}, 32'd0);
        chk("rst_done", {31'b0, Done_o}, 32'd0);
        chk("rst_rdata", ReadData_o, 32'h0);
        chk("rst_misalign", {31'b0, Misalign_o}, 32'd0);
        MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].exp_rd);
            idle(1);
        end

        // Back-to-back loads with input scrambling during BUSY.
        model_apply(1'b1, 1'b0, 32'h4, 32'h0);
        access(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 32'hCAFE_F00D);
        first_done = last_done_cyc;
        model_apply(1'b1, 1'b0, 32'h8, 32'h0);
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h0000_0055);
        chk("b2b_spacing", 32'(last_done_cyc - first_done), 32'd4);
        idle(2);

        // Reset in the 2nd BUSY cycle of a write: write dropped.
        MemWrite_i  = 1'b1;
        Addr_i      = 32'h20;
        WriteData_i = 32'hAA;
        #1 chk("mid_idle_stall", {31'b0, Stall_o}, 32'd1);
        @(negedge clk_i);
        #1 chk("mid_busy1_stall", {31'b0, Stall_o}, 32'd1);
        @(negedge clk_i);
        #1 chk("mid_busy2_stall", {31'b0, Stall_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_stall", {31'b0, Stall_o}, 32'd0);
        chk("mid_rst_done", {31'b0, Done_o}, 32'd0);
        chk("mid_rst_rdata", ReadData_o, 32'h0);
        rd_m = 32'h0;
        @(negedge clk_i);
        MemWrite_i = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk_i);
        idle(1);
        model_apply(1'b1, 1'b0, 32'h20, 32'h0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd_m);
        chk("mid_old_contents", rd_m, 32'h1111_1111);
        idle(1);

`ifdef DMEM_MISALIGN_TRAP_EN
        MemRead_i = 1'b1;
        Addr_i    = 32'h6;
        #1;
        chk("mis_stall", {31'b0, Stall_o}, 32'd1);
        chk("mis_done0", {31'b0, Done_o}, 32'd0);
        @(negedge clk_i);
        #1;
        chk("mis_resp_stall", {31'b0, Stall_o}, 32'd0);
        chk("mis_resp_done", {31'b0, Done_o}, 32'd1);
        chk("mis_resp_flag", {31'b0, Misalign_o}, 32'd1);
        chk("mis_resp_rdata", ReadData_o, rd_m);
        @(negedge clk_i);
        idle(1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            ix = int'($urandom_range(0, 15));
            a  = ($urandom & 32'hFFFF_FC00) | (32'(ix) << 2);
`ifndef DMEM_MISALIGN_TRAP_EN
            a  = a | ($urandom & 32'h3);
`endif
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            if (!w && !val_m[widx(a)]) w = 1'b1;
            model_apply(r, w, a, $urandom);
            if (w) begin
                access(r, w, a, mem_m[widx(a)], 1'($urandom), rd_m);
            end else begin
                access(r, w, a, $urandom, 1'($urandom), rd_m);
            end
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the MEM-stage data-memory interface.
- Accepts the read/write request that the pipeline's EX/MEM register presents, then services it with a programmable number of wait states.
- Holds the pipeline via Stall_o until the request finishes, then returns read data for the MEM/WB register.
- Replaces the zero-latency data memory. The request-side signal names are unchanged.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of 2.
- WAIT_CYCLES, 2: wait states per access; must be ≥1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- MemRead_i  in  1  read request, level-held by the stalled pipeline.
- MemWrite_i  in  1  write request, level-held.
- Addr_i  in  32  byte address (the ALU result).
- WriteData_i  in  32  store data.
- ReadData_o  out  32  registered load data.
- Stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- Done_o  out  1  one-cycle pulse when an access completes.
- Misalign_o  out  1  one-cycle pulse; only exists with the optional feature.

Behaviour:
- Reset values: state=IDLE, cnt=0, ReadData_o=0, Done_o=0, Misalign_o=0. Stall_o=0 while reset is asserted.
- Storage array contents are not reset.
- Word index = Addr_i[2 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so addresses wrap modulo the depth. Addr_i[1:0] are ignored unless the optional feature is enabled.
- req = MemRead_i | MemWrite_i. If both are high, the request is a write and ReadData_o is not updated.
- IDLE:
  - If req, latch op, index and WriteData_i; load cnt=WAIT_CYCLES-1; go to BUSY.
  - Stall_o = req, combinational in this cycle.
- BUSY:
  - Stall_o=1.
  - If cnt==0, go to RESP; otherwise cnt-=1.
  - On the BUSY→RESP edge: a write commits the latched data to the array; a read loads ReadData_o from the array.
- RESP:
  - Stall_o=0 and Done_o=1, so the pipeline advances on this edge.
  - Always return to IDLE. RESP never accepts a new request.
- Timing: a request first seen in IDLE at cycle t stalls cycles t..t+WAIT_CYCLES (WAIT_CYCLES+1 cycles). RESP is at cycle t+WAIT_CYCLES+1.
- Back-to-back requests: the next instruction reaches MEM in the IDLE cycle after RESP and is accepted there. No extra bubble.
- ReadData_o holds its value until the next read completes. It is unchanged by writes and by idle cycles.
- Latched values are used throughout BUSY. Input changes after acceptance are ignored.
- Reset during BUSY returns to IDLE. An uncommitted write is dropped and the array is left unchanged.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A request in IDLE with Addr_i[1:0]≠0 goes directly to RESP with no array access.
  - Stall_o is 1 for that single IDLE cycle.
  - In RESP, Misalign_o=1 and Done_o=1; ReadData_o is unchanged.
- Undefined: Misalign_o is tied to 0 and the low address bits are ignored.

Decomposition:
- dmem_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - DMEM_ADDR_LSB=2;
  - the op encoding {OP_RD, OP_WR}.
- Sub-module dmem_array: DEPTH_WORDS×32 storage with synchronous write-enable and asynchronous read. The FSM, counter and output registers stay in dmem_responder.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - MemWrite_i=1, Addr_i=0x10, WriteData_i=0xDEADBEEF → Stall_o high for 3 cycles, Done_o pulses on the 4th.
  - Then MemRead_i at 0x10 → ReadData_o=0xDEADBEEF after 3 stall cycles.
- Wrap-around, DEPTH_WORDS=256: write 0x1234 to 0x400, read 0x000 → 0x1234.
- Simultaneous MemRead_i=MemWrite_i=1 with data 0x55 to 0x8 → write occurs, ReadData_o keeps its prior value, a later read of 0x8 returns 0x55.
- Reset mid-access: assert rst_i low in the 2nd BUSY cycle of a write of 0xAA to 0x20 → Stall_o=0 and state IDLE immediately; a later read of 0x20 returns the old contents.
- Back-to-back: loads at 0x4 and 0x8 on consecutive instructions → two Done_o pulses exactly 4 cycles apart with correct data each; input changes during BUSY are ignored.
- With DMEM_MISALIGN_TRAP_EN, read Addr_i=0x6 → Stall_o for 1 cycle, then Misalign_o=Done_o=1, ReadData_o unchanged.
